// File: rtl/tx_resp_pkg.sv
// Shared types and constants for the TX response FIFO.
// State encoding, default sizing and the width helper.
package tx_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_DEPTH        = 8;
    localparam int DEF_HOLD_TIMEOUT = 255;

    // Number of bits needed to hold the values 0 .. n-1 (minimum 1).
    function automatic int bits_for(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock circular FIFO: storage, pointers, occupancy, FULL/EMPTY.
// A push at full is refused even when a pop happens in the same cycle.
module sync_fifo_core
    import tx_resp_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    assign w_full    = (r_count == (ADDR_WIDTH+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && !w_empty;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

    // Storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally mod DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tx_resp_fifo.sv
// Response buffer between the system controller and the UART Data_Sync.
// Bytes are released one at a time with a level-held vld that stays up
// until the transmitter reports busy, or until the hold timer expires.
// Optional feature: define TX_RESP_FIFO_OVF_FLAG_EN to add the sticky
// overflow flag OVF and its clear input OVF_CLR.
module tx_resp_fifo
    import tx_resp_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_WIDTH   = 3,
    parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_VLD,
    input  logic                  TX_Busy,
`ifdef TX_RESP_FIFO_OVF_FLAG_EN
    input  logic                  OVF_CLR,
    output logic                  OVF,
`endif
    output logic [DATA_WIDTH-1:0] TX_send,
    output logic                  vld,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  TO_ERR
);

    localparam int TMR_W = bits_for(HOLD_TIMEOUT + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] r_tx_send;
    logic [DATA_WIDTH-1:0] w_tx_nxt;
    logic                  r_vld;
    logic                  w_vld_nxt;
    logic                  r_to_err;
    logic                  w_to_nxt;
    logic [TMR_W-1:0]      r_timer;
    logic [TMR_W-1:0]      w_tmr_nxt;

    sync_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .i_clk       (CLK),
        .i_rst_n     (RST),
        .i_push      (WR_VLD),
        .i_push_data (WR_DATA),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (COUNT)
    );

    assign FULL    = w_full;
    assign EMPTY   = w_empty;
    assign TX_send = r_tx_send;
    assign vld     = r_vld;
    assign TO_ERR  = r_to_err;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and next values for the handshake outputs and timer.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tx_nxt    = r_tx_send;
        w_vld_nxt   = 1'b0;
        w_to_nxt    = 1'b0;
        w_tmr_nxt   = r_timer;
        case (r_state)
            IDLE: begin
                // A transmitter still busy from an earlier frame blocks the pop.
                if (!w_empty && !TX_Busy) begin
                    w_pop       = 1'b1;
                    w_tx_nxt    = w_head;
                    w_vld_nxt   = 1'b1;
                    w_tmr_nxt   = '0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                w_vld_nxt = 1'b1;
                if (TX_Busy) begin
                    w_vld_nxt   = 1'b0;
                    w_state_nxt = DRAIN;
                end else if (r_timer == TMR_W'(HOLD_TIMEOUT)) begin
                    // Transmitter never picked the byte up: drop it and flag.
                    w_vld_nxt   = 1'b0;
                    w_to_nxt    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmr_nxt = r_timer + TMR_W'(1);
                end
            end
            DRAIN: begin
                if (!TX_Busy) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Registered handshake outputs and hold timer.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tx_send <= '0;
            r_vld     <= 1'b0;
            r_to_err  <= 1'b0;
            r_timer   <= '0;
        end else begin
            r_tx_send <= w_tx_nxt;
            r_vld     <= w_vld_nxt;
            r_to_err  <= w_to_nxt;
            r_timer   <= w_tmr_nxt;
        end
    end

`ifdef TX_RESP_FIFO_OVF_FLAG_EN
    logic r_ovf;

    assign OVF = r_ovf;

    // Sticky overflow flag; a new drop outranks a simultaneous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ovf <= 1'b0;
        end else if (WR_VLD && w_full) begin
            r_ovf <= 1'b1;
        end else if (OVF_CLR) begin
            r_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_tx_resp_fifo.sv
// Self-checking bench for tx_resp_fifo: queue-based reference model
// compared every cycle, plus directed literal checks.
module tb_tx_resp_fifo;

    localparam int DW   = 8;
    localparam int DEP  = 8;
    localparam int AW   = 3;
    localparam int HTO  = 255;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [DW-1:0] WR_DATA = '0;
    logic          WR_VLD = 1'b0;
    logic          TX_Busy = 1'b0;
    logic [DW-1:0] TX_send;
    logic          vld;
    logic          FULL;
    logic          EMPTY;
    logic [AW:0]   COUNT;
    logic          TO_ERR;
`ifdef TX_RESP_FIFO_OVF_FLAG_EN
    logic          OVF_CLR = 1'b0;
    logic          OVF;
`endif

    tx_resp_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEP),
        .ADDR_WIDTH   (AW),
        .HOLD_TIMEOUT (HTO)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .WR_DATA (WR_DATA),
        .WR_VLD  (WR_VLD),
        .TX_Busy (TX_Busy),
`ifdef TX_RESP_FIFO_OVF_FLAG_EN
        .OVF_CLR (OVF_CLR),
        .OVF     (OVF),
`endif
        .TX_send (TX_send),
        .vld     (vld),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .COUNT   (COUNT),
        .TO_ERR  (TO_ERR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Bytes waiting, the byte on offer, how long it has been offered,
    // and whether we are waiting for the transmitter to go idle again.
    logic [DW-1:0] q[$];
    bit            m_vld  = 1'b0;
    logic [DW-1:0] m_tx   = '0;
    bit            m_to   = 1'b0;
    int            m_hold = 0;
    bit            m_wait = 1'b0;
    bit            m_ovf  = 1'b0;

    always @(posedge CLK or negedge RST) begin : model
        int sz;
        if (!RST) begin
            q.delete();
            m_vld  = 1'b0;
            m_tx   = '0;
            m_to   = 1'b0;
            m_hold = 0;
            m_wait = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            sz   = q.size();
            m_to = 1'b0;
            if (m_vld) begin
                if (TX_Busy) begin
                    m_vld  = 1'b0;
                    m_wait = 1'b1;
                end else if (m_hold == HTO) begin
                    m_vld = 1'b0;
                    m_to  = 1'b1;
                end else begin
                    m_hold++;
                end
            end else if (m_wait) begin
                if (!TX_Busy) m_wait = 1'b0;
            end else if (sz > 0 && !TX_Busy) begin
                m_tx   = q.pop_front();
                m_vld  = 1'b1;
                m_hold = 0;
            end
            if (WR_VLD) begin
                if (sz < DEP) q.push_back(WR_DATA);
                else m_ovf = 1'b1;
            end
`ifdef TX_RESP_FIFO_OVF_FLAG_EN
            else if (OVF_CLR) m_ovf = 1'b0;
`endif
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            check("vld",     {31'd0, vld},     {31'd0, m_vld});
            check("TX_send", {24'd0, TX_send}, {24'd0, m_tx});
            check("COUNT",   {28'd0, COUNT},   q.size());
            check("FULL",    {31'd0, FULL},    {31'd0, (q.size() == DEP)});
            check("EMPTY",   {31'd0, EMPTY},   {31'd0, (q.size() == 0)});
            check("TO_ERR",  {31'd0, TO_ERR},  {31'd0, m_to});
`ifdef TX_RESP_FIFO_OVF_FLAG_EN
            check("OVF",     {31'd0, OVF},     {31'd0, m_ovf});
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [DW-1:0] got [0:15];

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic write_byte(input logic [DW-1:0] b);
        WR_DATA = b;
        WR_VLD  = 1'b1;
        tick();
        WR_VLD  = 1'b0;
    endtask

    // Accept n bytes: wait for vld, capture, then hold TX_Busy for busy_len cycles.
    task automatic serve(input int n, input int busy_len);
        bit seen_vld_busy;
        bit ok;
        for (int i = 0; i < n; i++) begin
            ok = 1'b0;
            for (int t = 0; t < 400; t++) begin
                if (vld) begin
                    ok = 1'b1;
                    break;
                end
                tick();
            end
            if (!ok) begin
                check("serve_wait_vld", 32'd0, 32'd1);
                return;
            end
            got[i] = TX_send;
            TX_Busy = 1'b1;
            tick();
            seen_vld_busy = 1'b0;
            for (int t = 0; t < busy_len; t++) begin
                if (vld) seen_vld_busy = 1'b1;
                tick();
            end
            check("vld_while_busy", {31'd0, seen_vld_busy}, 32'd0);
            TX_Busy = 1'b0;
        end
    endtask

    initial begin
        int vld_cycles;
        int to_pulses;
        bit any_vld;
        bit ok;

        // Reset
        #1 RST = 1'b0;
        repeat (3) tick();
        check("rst_EMPTY",   {31'd0, EMPTY},   32'd1);
        check("rst_vld",     {31'd0, vld},     32'd0);
        check("rst_TX_send", {24'd0, TX_send}, 32'd0);
        check("rst_COUNT",   {28'd0, COUNT},   32'd0);
        check("rst_TO_ERR",  {31'd0, TO_ERR},  32'd0);
        RST = 1'b1;
        chk_en = 1'b1;
        repeat (2) tick();

        // Single byte
        write_byte(8'hA5);
        check("single_COUNT1", {28'd0, COUNT}, 32'd1);
        check("single_EMPTY0", {31'd0, EMPTY}, 32'd0);
        check("single_vld0",   {31'd0, vld},   32'd0);
        tick();
        check("single_vld1",    {31'd0, vld},     32'd1);
        check("single_TX_send", {24'd0, TX_send}, 32'hA5);
        check("single_COUNT0",  {28'd0, COUNT},   32'd0);
        TX_Busy = 1'b1;
        tick();
        check("single_vld_drop", {31'd0, vld}, 32'd0);
        check("single_TX_hold",  {24'd0, TX_send}, 32'hA5);
        tick();
        TX_Busy = 1'b0;
        repeat (3) tick();

        // Two-byte ALU result
        write_byte(8'h34);
        write_byte(8'h12);
        serve(2, 40);
        check("alu_byte0", {24'd0, got[0]}, 32'h34);
        check("alu_byte1", {24'd0, got[1]}, 32'h12);
        repeat (4) tick();
        check("alu_EMPTY", {31'd0, EMPTY}, 32'd1);

        // Full / overflow
        TX_Busy = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            WR_DATA = DW'(i + 1);
            WR_VLD  = 1'b1;
            tick();
            if (i == 7) begin
                check("full_after8",  {31'd0, FULL},  32'd1);
                check("count_after8", {28'd0, COUNT}, 32'd8);
            end
        end
        WR_VLD = 1'b0;
        check("full_after9",  {31'd0, FULL},  32'd1);
        check("count_after9", {28'd0, COUNT}, 32'd8);
`ifdef TX_RESP_FIFO_OVF_FLAG_EN
        check("ovf_set", {31'd0, OVF}, 32'd1);
`endif
        TX_Busy = 1'b0;
        serve(8, 3);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_byte%0d", i), {24'd0, got[i]}, i + 1);
        end
        repeat (4) tick();
        check("drain_EMPTY", {31'd0, EMPTY}, 32'd1);

        // Timeout: byte offered and never accepted
        write_byte(8'h5A);
        vld_cycles = 0;
        to_pulses  = 0;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (vld) vld_cycles++;
            if (TO_ERR) to_pulses++;
        end
        check("timeout_vld_cycles", vld_cycles, HTO + 1);
        check("timeout_pulses",     to_pulses,  32'd1);
        check("timeout_COUNT",      {28'd0, COUNT}, 32'd0);
        check("timeout_vld_low",    {31'd0, vld},   32'd0);

        // Reset during HOLD with bytes queued
        TX_Busy = 1'b1;
        write_byte(8'hC1);
        write_byte(8'hC2);
        write_byte(8'hC3);
        write_byte(8'hC4);
        TX_Busy = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (vld) begin
                ok = 1'b1;
                break;
            end
        end
        check("rstmid_reached_hold", {31'd0, ok}, 32'd1);
        check("rstmid_queued",       {28'd0, COUNT}, 32'd3);
        #1 RST = 1'b0;
        #1;
        check("rstmid_vld",   {31'd0, vld},   32'd0);
        check("rstmid_COUNT", {28'd0, COUNT}, 32'd0);
        check("rstmid_EMPTY", {31'd0, EMPTY}, 32'd1);
        tick();
        tick();
        RST = 1'b1;
        any_vld = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (vld) any_vld = 1'b1;
        end
        check("rstmid_no_emit", {31'd0, any_vld}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
